// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-seg scan sequencer: dwell/guard digit scan, frame-aligned data
// latch handshake, and optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIGITS       = 3,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  UPDATE_REQ,
  output logic                  UPDATE_ACK,
  output logic                  LATCH_ENA_N,
  input  logic [4*DIGITS-1:0]   LATCHED,
  input  logic                  BLANK_LZ,
  output logic [DIGITS-1:0]     DIGIT_SEL_N,
  output logic [3:0]            NIBBLE
);
  localparam int CMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DIV_LD   = CW'(DIV);
  localparam logic [CW-1:0] BLK_LD   = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {S_GUARD, S_ON, S_LATCH, S_SETTLE} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [3:0]          nib_q, nib_d;
  logic                ena_n_q, ena_n_d;
  logic                ack_q, ack_d;

  logic [DIGITS-1:0]   blank_mask;
  logic                allz;
  logic                go_scan, go_on;
  logic [IW-1:0]       scan_idx;

  // blank_mask[i]: digit i and every more-significant nibble are zero
  always_comb begin
    blank_mask = '0;
    allz       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz = allz && (LATCHED[4*i +: 4] == 4'h0);
      if (i > 0) blank_mask[i] = BLANK_LZ && allz;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    nib_d    = nib_q;
    ena_n_d  = 1'b1;
    ack_d    = 1'b0;
    go_scan  = 1'b0;
    go_on    = 1'b0;
    scan_idx = idx_q;

    unique case (state_q)
      S_GUARD: begin
        // counter 0 only happens right after reset: that edge acts as the guard entry
        if (BLANK_CYCLES == 0 || cnt_q == ONE) go_on = 1'b1;
        else if (cnt_q == '0)                  cnt_d = BLK_LD;
        else                                   cnt_d = cnt_q - ONE;
      end
      S_ON: begin
        if (cnt_q > ONE) begin
          cnt_d = cnt_q - ONE;
        end else if (idx_q != LAST_IDX) begin
          go_scan  = 1'b1;
          scan_idx = idx_q + IW'(1);
        end else if (UPDATE_REQ) begin
          state_d = S_LATCH;
          sel_d   = '1;
          ena_n_d = 1'b0;
          ack_d   = 1'b1;
        end else begin
          go_scan  = 1'b1;
          scan_idx = '0;
        end
      end
      S_LATCH:  state_d = S_SETTLE;
      S_SETTLE: begin
        go_scan  = 1'b1;
        scan_idx = '0;
      end
      default:  state_d = S_GUARD;
    endcase

    if (go_scan) begin
      idx_d = scan_idx;
      sel_d = '1;
      if (BLANK_CYCLES == 0) begin
        go_on = 1'b1;
      end else begin
        state_d = S_GUARD;
        cnt_d   = BLK_LD;
      end
    end

    // digit select and nibble are sampled once on ON entry, held for the dwell
    if (go_on) begin
      state_d = S_ON;
      idx_d   = scan_idx;
      cnt_d   = DIV_LD;
      if (blank_mask[scan_idx]) begin
        sel_d = '1;
        nib_d = 4'h0;
      end else begin
        sel_d = ~(DIGITS'(1) << scan_idx);
        nib_d = LATCHED[4*scan_idx +: 4];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '1;
      nib_q   <= 4'h0;
      ena_n_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      nib_q   <= nib_d;
      ena_n_q <= ena_n_d;
      ack_q   <= ack_d;
    end
  end

  assign DIGIT_SEL_N = sel_q;
  assign NIBBLE      = nib_q;
  assign LATCH_ENA_N = ena_n_q;
  assign UPDATE_ACK  = ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (DIGITS=3, DIV=4, BLANK_CYCLES=2),
// with a behavioural model of the external data latch.
module tb_display_scan_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        UPDATE_REQ;
  logic        UPDATE_ACK;
  logic        LATCH_ENA_N;
  logic [11:0] LATCHED;
  logic        BLANK_LZ;
  logic [2:0]  DIGIT_SEL_N;
  logic [3:0]  NIBBLE;
  logic [11:0] pend;
  int ncmp = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  display_scan_ctrl #(.DIGITS(3), .DIV(4), .BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE_REQ(UPDATE_REQ), .UPDATE_ACK(UPDATE_ACK),
    .LATCH_ENA_N(LATCH_ENA_N), .LATCHED(LATCHED), .BLANK_LZ(BLANK_LZ),
    .DIGIT_SEL_N(DIGIT_SEL_N), .NIBBLE(NIBBLE)
  );

  task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // one sampled cycle; the external latch captures pend when its enable is low
  task automatic cyc(input string tag, input logic [2:0] sel, input logic [3:0] nib,
                     input bit chk_nib, input logic ena, input logic ack);
    @(negedge CLK);
    chk({tag, ".sel"}, 12'(DIGIT_SEL_N), 12'(sel));
    if (chk_nib) chk({tag, ".nib"}, 12'(NIBBLE), 12'(nib));
    chk({tag, ".ena"}, 12'(LATCH_ENA_N), 12'(ena));
    chk({tag, ".ack"}, 12'(UPDATE_ACK), 12'(ack));
    if (LATCH_ENA_N === 1'b0) LATCHED = pend;
  endtask

  task automatic guard(input string tag);
    repeat (2) cyc({tag, ".g"}, 3'b111, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic on_cyc(input string tag, input int d, input logic [3:0] nib,
                        input bit shown, input int n);
    logic [2:0] s;
    s = shown ? ~(3'b001 << d) : 3'b111;
    for (int k = 0; k < n; k++)
      cyc({tag, ".on"}, s, shown ? nib : 4'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic digit(input string tag, input int d, input logic [3:0] nib, input bit shown);
    guard(tag);
    on_cyc(tag, d, nib, shown, 4);
  endtask

  task automatic frame(input string tag, input logic [11:0] v, input logic [2:0] shown);
    digit({tag, "d0"}, 0, v[3:0],  shown[0]);
    digit({tag, "d1"}, 1, v[7:4],  shown[1]);
    digit({tag, "d2"}, 2, v[11:8], shown[2]);
  endtask

  task automatic latch(input string tag);
    cyc({tag, ".latch"},  3'b111, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc({tag, ".settle"}, 3'b111, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    RST_N = 1'b0; UPDATE_REQ = 1'b0; BLANK_LZ = 1'b0;
    LATCHED = 12'h123; pend = 12'h456;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst.sel", 12'(DIGIT_SEL_N), 12'h7);
    chk("rst.nib", 12'(NIBBLE), 12'h0);
    chk("rst.ena", 12'(LATCH_ENA_N), 12'h1);
    chk("rst.ack", 12'(UPDATE_ACK), 12'h0);
    #1 RST_N = 1'b1;

    // plain scan, no request: 18-cycle frame, enable never low
    frame("f1", 12'h123, 3'b111);

    // request raised mid digit 1: latch only after the last ON cycle of digit 2
    digit("f2d0", 0, 4'h3, 1'b1);
    guard("f2d1");
    on_cyc("f2d1a", 1, 4'h2, 1'b1, 2);
    UPDATE_REQ = 1'b1;
    on_cyc("f2d1b", 1, 4'h2, 1'b1, 2);
    digit("f2d2", 2, 4'h1, 1'b1);
    latch("f2");
    UPDATE_REQ = 1'b0;

    frame("f3", 12'h456, 3'b111);
    // request held high from here: one latch per 20-cycle frame
    UPDATE_REQ = 1'b1; pend = 12'h789;
    latch("f3");
    pend = 12'hA0F;
    frame("f4", 12'h789, 3'b111);
    latch("f4");
    pend = 12'h005;
    frame("f5", 12'hA0F, 3'b111);
    latch("f5");
    pend = 12'h000; BLANK_LZ = 1'b1;
    frame("f6", 12'h005, 3'b001);
    latch("f6");
    pend = 12'h050;
    frame("f7", 12'h000, 3'b001);
    latch("f7");
    pend = 12'h321;
    frame("f8", 12'h050, 3'b011);

    // reset during the latch cycle
    @(posedge CLK); #2;
    chk("rl.pre.ena", 12'(LATCH_ENA_N), 12'h0);
    chk("rl.pre.ack", 12'(UPDATE_ACK), 12'h1);
    RST_N = 1'b0;
    #1;
    chk("rl.ena", 12'(LATCH_ENA_N), 12'h1);
    chk("rl.ack", 12'(UPDATE_ACK), 12'h0);
    chk("rl.sel", 12'(DIGIT_SEL_N), 12'h7);
    chk("rl.nib", 12'(NIBBLE), 12'h0);
    UPDATE_REQ = 1'b0; BLANK_LZ = 1'b0;
    @(negedge CLK); #2 RST_N = 1'b1;
    digit("post0", 0, 4'h0, 1'b1);
    digit("post1", 1, 4'h5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
